// File: rtl/sc_regshifter_seq_pkg.sv
// Shared encodings for the sequential shift register: operation modes, FSM states
// and the shift-amount width derivation.
package sc_regshifter_seq_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LSL  = 3'b001;
    localparam logic [2:0] MODE_LSR  = 3'b010;
    localparam logic [2:0] MODE_ASR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_SLI  = 3'b110;
    localparam logic [2:0] MODE_SRI  = 3'b111;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_SHIFT = 2'd1,
        STATE_DONE  = 2'd2
    } shiftState_t;

    function automatic int amountWidth(input int busWidth);
        return $clog2(busWidth);
    endfunction

endpackage

// File: rtl/sc_shift_step.sv
// Combinational single-bit shifter: applies one step of the selected mode to a word
// and reports the bit that leaves it (the wrapped bit for rotates).
module sc_shift_step
    import sc_regshifter_seq_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32
) (
    input  logic [2:0]               stepMode,
    input  logic [DATAWIDTH_BUS-1:0] stepWord,
    input  logic                     stepSerial,
    output logic [DATAWIDTH_BUS-1:0] stepNext,
    output logic                     stepOutBit
);

    always_comb begin
        stepNext   = stepWord;
        stepOutBit = 1'b0;
        case (stepMode)
            MODE_LSL: begin
                stepNext   = {stepWord[DATAWIDTH_BUS-2:0], 1'b0};
                stepOutBit = stepWord[DATAWIDTH_BUS-1];
            end
            MODE_LSR: begin
                stepNext   = {1'b0, stepWord[DATAWIDTH_BUS-1:1]};
                stepOutBit = stepWord[0];
            end
            MODE_ASR: begin
                stepNext   = {stepWord[DATAWIDTH_BUS-1], stepWord[DATAWIDTH_BUS-1:1]};
                stepOutBit = stepWord[0];
            end
            MODE_ROL: begin
                stepNext   = {stepWord[DATAWIDTH_BUS-2:0], stepWord[DATAWIDTH_BUS-1]};
                stepOutBit = stepWord[DATAWIDTH_BUS-1];
            end
            MODE_ROR: begin
                stepNext   = {stepWord[0], stepWord[DATAWIDTH_BUS-1:1]};
                stepOutBit = stepWord[0];
            end
            MODE_SLI: begin
                stepNext   = {stepWord[DATAWIDTH_BUS-2:0], stepSerial};
                stepOutBit = stepWord[DATAWIDTH_BUS-1];
            end
            MODE_SRI: begin
                stepNext   = {stepSerial, stepWord[DATAWIDTH_BUS-1:1]};
                stepOutBit = stepWord[0];
            end
            default: begin
                stepNext   = stepWord;
                stepOutBit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sc_regshifter_seq.sv
// Sequential shift/rotate register: one bit position per clock after a Start pulse.
// Handshake: Start is accepted only in IDLE with Load_InLow high; Busy is high for the k
// shifting cycles; Done pulses for one cycle when the result is final; Start while Busy/Done is ignored.
module sc_regshifter_seq
    import sc_regshifter_seq_pkg::*;
#(
    parameter int DATAWIDTH_BUS    = 32,
    parameter int DATAWIDTH_MODE   = 3,
    parameter int DATAWIDTH_AMOUNT = amountWidth(DATAWIDTH_BUS)
) (
    input  logic                        SC_RegSHIFTSEQ_CLOCK_50,
    input  logic                        SC_RegSHIFTSEQ_Reset_InLow,
    input  logic                        SC_RegSHIFTSEQ_Load_InLow,
    input  logic                        SC_RegSHIFTSEQ_Start_InHigh,
    input  logic [DATAWIDTH_MODE-1:0]   SC_RegSHIFTSEQ_Mode_In,
    input  logic [DATAWIDTH_AMOUNT-1:0] SC_RegSHIFTSEQ_Amount_In,
    input  logic                        SC_RegSHIFTSEQ_SerialIn,
    input  logic [DATAWIDTH_BUS-1:0]    SC_RegSHIFTSEQ_DataBUS_In,
    output logic [DATAWIDTH_BUS-1:0]    SC_RegSHIFTSEQ_DataBUS_Out,
    output logic                        SC_RegSHIFTSEQ_Busy_OutHigh,
    output logic                        SC_RegSHIFTSEQ_Done_OutHigh,
    output logic                        SC_RegSHIFTSEQ_Carry_Out,
    output logic                        SC_RegSHIFTSEQ_Zero_Out,
    output logic [1:0]                  SC_RegSHIFTSEQ_State_Out
);

    localparam logic [DATAWIDTH_AMOUNT-1:0] AMOUNT_MAX = DATAWIDTH_AMOUNT'(DATAWIDTH_BUS - 1);
    localparam logic [DATAWIDTH_AMOUNT-1:0] AMOUNT_ONE = DATAWIDTH_AMOUNT'(1);

    shiftState_t                 stateCurrent;
    shiftState_t                 stateNext;
    logic [DATAWIDTH_BUS-1:0]    regData;
    logic                        regCarry;
    logic [DATAWIDTH_AMOUNT-1:0] shiftCounter;
    logic [DATAWIDTH_MODE-1:0]   modeLatched;
    logic [DATAWIDTH_AMOUNT-1:0] amountSat;
    logic [DATAWIDTH_BUS-1:0]    stepNext;
    logic                        stepOutBit;
    logic                        startAccepted;

    // Only reachable when the bus width is not a power of two.
    assign amountSat = (32'(SC_RegSHIFTSEQ_Amount_In) > 32'(DATAWIDTH_BUS - 1)) ?
                       AMOUNT_MAX : SC_RegSHIFTSEQ_Amount_In;

    assign startAccepted = SC_RegSHIFTSEQ_Load_InLow && SC_RegSHIFTSEQ_Start_InHigh;

    sc_shift_step #(
        .DATAWIDTH_BUS(DATAWIDTH_BUS)
    ) u_shift_step (
        .stepMode   (modeLatched[2:0]),
        .stepWord   (regData),
        .stepSerial (SC_RegSHIFTSEQ_SerialIn),
        .stepNext   (stepNext),
        .stepOutBit (stepOutBit)
    );

    always_ff @(posedge SC_RegSHIFTSEQ_CLOCK_50) begin
        if (!SC_RegSHIFTSEQ_Reset_InLow) begin
            stateCurrent <= STATE_IDLE;
        end else begin
            stateCurrent <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateCurrent;
        case (stateCurrent)
            STATE_IDLE: begin
                if (startAccepted) begin
                    stateNext = (amountSat == '0) ? STATE_DONE : STATE_SHIFT;
                end
            end
            STATE_SHIFT: begin
                if (shiftCounter == AMOUNT_ONE) begin
                    stateNext = STATE_DONE;
                end
            end
            STATE_DONE: stateNext = STATE_IDLE;
            default:    stateNext = STATE_IDLE;
        endcase
    end

    always_ff @(posedge SC_RegSHIFTSEQ_CLOCK_50) begin
        if (!SC_RegSHIFTSEQ_Reset_InLow) begin
            regData      <= '0;
            regCarry     <= 1'b0;
            shiftCounter <= '0;
            modeLatched  <= '0;
        end else begin
            case (stateCurrent)
                STATE_IDLE: begin
                    if (!SC_RegSHIFTSEQ_Load_InLow) begin
                        regData <= SC_RegSHIFTSEQ_DataBUS_In;
                    end else if (SC_RegSHIFTSEQ_Start_InHigh) begin
                        modeLatched  <= SC_RegSHIFTSEQ_Mode_In;
                        shiftCounter <= amountSat;
                        if (amountSat == '0) begin
                            regCarry <= 1'b0;
                        end
                    end
                end
                STATE_SHIFT: begin
                    // HOLD still burns the requested number of cycles.
                    shiftCounter <= shiftCounter - AMOUNT_ONE;
                    if (modeLatched[2:0] != MODE_HOLD) begin
                        regData  <= stepNext;
                        regCarry <= stepOutBit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign SC_RegSHIFTSEQ_DataBUS_Out  = regData;
    assign SC_RegSHIFTSEQ_Busy_OutHigh = (stateCurrent == STATE_SHIFT);
    assign SC_RegSHIFTSEQ_Done_OutHigh = (stateCurrent == STATE_DONE);
    assign SC_RegSHIFTSEQ_Carry_Out    = regCarry;
    assign SC_RegSHIFTSEQ_Zero_Out     = (regData == '0);
    assign SC_RegSHIFTSEQ_State_Out    = stateCurrent;

endmodule

// File: tb/tb_sc_regshifter_seq.sv
// Bench for sc_regshifter_seq at 8 bits: a scoreboard of final {carry, word} results
// fed from a whole-operation arithmetic model, plus per-cycle trajectory checks.
module tb_sc_regshifter_seq;

    localparam int W  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_n;
    logic          start;
    logic [2:0]    mode;
    logic [AW-1:0] amount;
    logic          serial_in;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic          busy;
    logic          done;
    logic          carry;
    logic          zero;
    logic [1:0]    state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W:0]   exp_q[$];
    logic [W-1:0] ref_word;
    logic         ref_carry;

    sc_regshifter_seq #(
        .DATAWIDTH_BUS(W),
        .DATAWIDTH_MODE(3),
        .DATAWIDTH_AMOUNT(AW)
    ) dut (
        .SC_RegSHIFTSEQ_CLOCK_50     (clk),
        .SC_RegSHIFTSEQ_Reset_InLow  (rst_n),
        .SC_RegSHIFTSEQ_Load_InLow   (load_n),
        .SC_RegSHIFTSEQ_Start_InHigh (start),
        .SC_RegSHIFTSEQ_Mode_In      (mode),
        .SC_RegSHIFTSEQ_Amount_In    (amount),
        .SC_RegSHIFTSEQ_SerialIn     (serial_in),
        .SC_RegSHIFTSEQ_DataBUS_In   (data_in),
        .SC_RegSHIFTSEQ_DataBUS_Out  (data_out),
        .SC_RegSHIFTSEQ_Busy_OutHigh (busy),
        .SC_RegSHIFTSEQ_Done_OutHigh (done),
        .SC_RegSHIFTSEQ_Carry_Out    (carry),
        .SC_RegSHIFTSEQ_Zero_Out     (zero),
        .SC_RegSHIFTSEQ_State_Out    (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Whole-operation result after k steps: {carry, word}. sb[i] is the serial bit of step i.
    function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic c, input logic [2:0] m,
                                          input int k, input logic [W-1:0] sb);
        logic [W-1:0] w;
        logic [W-1:0] ins;
        logic         co;
        if (k == 0) return {1'b0, x};
        ins = '0;
        w   = x;
        co  = c;
        case (m)
            3'b001: begin w = x << k; co = x[W-k]; end
            3'b010: begin w = x >> k; co = x[k-1]; end
            3'b011: begin w = $signed(x) >>> k; co = x[k-1]; end
            3'b100: begin w = (x << k) | (x >> (W-k)); co = x[W-k]; end
            3'b101: begin w = (x >> k) | (x << (W-k)); co = x[k-1]; end
            3'b110: begin
                for (int i = 0; i < k; i++) ins[k-1-i] = sb[i];
                w = (x << k) | ins; co = x[W-k];
            end
            3'b111: begin
                for (int i = 0; i < k; i++) ins[W-k+i] = sb[i];
                w = (x >> k) | ins; co = x[k-1];
            end
            default: begin w = x; co = c; end
        endcase
        return {co, w};
    endfunction

    // scoreboard monitor: every Done pulse must match the oldest expected result
    always @(negedge clk) begin
        logic [W:0] e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("done_word",  32'(data_out), 32'(e[W-1:0]));
                check("done_carry", 32'(carry),    32'(e[W]));
                check("done_zero",  32'(zero),     32'(e[W-1:0] == '0));
            end
        end
    end

    // driver tasks (inputs change at posedge+1)
    task automatic do_load(input logic [W-1:0] d);
        load_n  = 1'b0;
        data_in = d;
        @(posedge clk); #1;
        load_n  = 1'b1;
        data_in = W'($urandom);
        ref_word = d;
    endtask

    task automatic run_op(input logic [2:0] m, input int k, input bit junk, input logic [W-1:0] bits);
        logic [W:0] r;
        logic [W:0] mid;
        int n;
        r = ref_op(ref_word, ref_carry, m, k, bits);
        exp_q.push_back(r);
        mode      = m;
        amount    = AW'(k);
        start     = 1'b1;
        serial_in = bits[0];
        @(posedge clk); #1;
        start  = 1'b0;
        mode   = 3'($urandom);
        amount = AW'($urandom);
        for (int j = 0; j < k; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            serial_in = bits[j];
            if (junk) begin
                load_n  = 1'($urandom_range(0, 1));
                start   = 1'($urandom_range(0, 1));
                data_in = W'($urandom);
            end
            @(negedge clk);
            mid = ref_op(ref_word, ref_carry, m, j, bits);
            check("busy_during_shift", 32'(busy), 32'd1);
            check("step_word", 32'(data_out), 32'(mid[W-1:0]));
        end
        if (k > 0) begin @(posedge clk); #1; end
        load_n = 1'b1;
        start  = 1'b0;
        @(negedge clk);
        check("done_on_time", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        n = 0;
        @(posedge clk); #1;
        while ((busy !== 1'b0 || done !== 1'b0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            tests_run++;
            tests_failed++;
            $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle within 40 cycles", busy, done);
        end
        ref_word  = r[W-1:0];
        ref_carry = r[W];
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out"},   32'(data_out), 32'd0);
        check({tag, "_zero"},  32'(zero),     32'd1);
        check({tag, "_carry"}, 32'(carry),    32'd0);
        check({tag, "_busy"},  32'(busy),     32'd0);
        check({tag, "_done"},  32'(done),     32'd0);
    endtask

    initial begin
        rst_n = 1'b0; load_n = 1'b1; start = 1'b0; mode = '0; amount = '0;
        serial_in = 1'b0; data_in = '0;
        ref_word = '0; ref_carry = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("por");

        // random activity, then a single reset edge
        do_load(W'($urandom));
        run_op(3'($urandom_range(1, 7)), $urandom_range(1, 7), 1'b0, W'($urandom));
        do_load(W'($urandom_range(1, 255)));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");
        ref_word = '0; ref_carry = 1'b0;

        // directed operations
        do_load(8'h96);
        run_op(3'b001, 3, 1'b0, 8'h00);
        check("lsl_result", 32'(data_out), 32'h00B0);
        check("lsl_carry",  32'(carry),    32'd0);
        do_load(8'h96);
        run_op(3'b011, 2, 1'b0, 8'h00);
        check("asr_result", 32'(data_out), 32'h00E5);
        check("asr_carry",  32'(carry),    32'd1);
        do_load(8'h96);
        run_op(3'b101, 4, 1'b0, 8'h00);
        check("ror_result", 32'(data_out), 32'h0069);
        check("ror_carry",  32'(carry),    32'd0);
        do_load(8'h00);
        run_op(3'b110, 3, 1'b0, 8'b0000_0101);
        check("sli_result", 32'(data_out), 32'h0005);
        do_load(8'h00);
        run_op(3'b111, 7, 1'b0, 8'hFF);
        check("sri_result", 32'(data_out), 32'h00FE);

        // zero amount: no Busy, Done next cycle, word unchanged, carry cleared
        do_load(8'hA5);
        run_op(3'b100, 0, 1'b0, 8'h00);
        check("k0_result", 32'(data_out), 32'h00A5);
        check("k0_carry",  32'(carry),    32'd0);

        // load and start together: load wins, no operation
        load_n = 1'b0; start = 1'b1; data_in = 8'h3C; mode = 3'b001; amount = 3'd3;
        @(posedge clk); #1;
        load_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("load_start_out",  32'(data_out), 32'h003C);
        check("load_start_busy", 32'(busy),     32'd0);
        check("load_start_done", 32'(done),     32'd0);
        @(negedge clk);
        check("load_start_done2", 32'(done), 32'd0);
        ref_word = 8'h3C;

        // reset mid-shift: LSL k=6 interrupted after two steps
        do_load(8'h96);
        mode = 3'b001; amount = 3'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("mid_shift_word", 32'(data_out), 32'h0058);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("mid_reset");
        ref_word = '0; ref_carry = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // randomized operations with junk on Load/Start/Data during SHIFT
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) do_load(W'($urandom));
            run_op(3'($urandom), $urandom_range(0, 7), 1'b1, W'($urandom));
        end

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
